// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-lite types: bus geometry, arbiter FSM states and the
// round-robin grant helper used by both arbiter channels.
package axi4_lite_pkg;

    typedef struct packed {
        int unsigned A;
        int unsigned N;
    } axi4_lite_cfg_t;

    localparam axi4_lite_cfg_t AXI4_LITE_CFG_DEFAULT = '{default: 0, A: 16, N: 4};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } axi4_lite_arb_state_t;

    // On a tie the port that was not granted last wins; otherwise the sole requester.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-lite bundle; master drives requests, slave drives readys and responses.
interface axi4_lite_if
    import axi4_lite_pkg::*;
#(
    parameter axi4_lite_cfg_t C = AXI4_LITE_CFG_DEFAULT
);
    localparam int unsigned AW = C.A;
    localparam int unsigned DW = C.N * 8;
    localparam int unsigned SW = C.N;

    logic          awvalid;
    logic          awready;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          wvalid;
    logic          wready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          bvalid;
    logic          bready;
    logic [1:0]    bresp;
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/axi4_lite_arb_channel.sv
// One arbitrated AXI4-lite path: grant register, last-grant pointer and
// address-phase done flags. Used once for writes, once for reads.
//
//   state | meaning
//   IDLE  | no grant; any request is latched into grant and moves to ADDR
//   ADDR  | granted port's address (and data) beats forwarded until all done
//   RESP  | response routed to granted port; handshake returns to IDLE
module axi4_lite_arb_channel
    import axi4_lite_pkg::*;
#(
    parameter bit TWO_CH    = 1'b1,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [1:0]           req_i,
    input  logic                 addr_hs0_i,
    input  logic                 addr_hs1_i,
    input  logic                 resp_hs_i,
    output axi4_lite_arb_state_t state_o,
    output logic                 grant_o,
    output logic                 done0_o,
    output logic                 done1_o
);

    axi4_lite_arb_state_t state_q, state_d;
    logic grant_q, grant_d;
    logic last_q, last_d;
    logic done0_q, done0_d;
    logic done1_q, done1_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        done0_d = done0_q;
        done1_d = done1_q;
        unique case (state_q)
            IDLE: begin
                if (|req_i) begin
                    grant_d = rr_pick(req_i, FIXED_PRI ? 1'b1 : last_q);
                    state_d = ADDR;
                end
            end
            ADDR: begin
                done0_d = done0_q | addr_hs0_i;
                done1_d = done1_q | addr_hs1_i | !TWO_CH;
                if (done0_d && done1_d) begin
                    state_d = RESP;
                    done0_d = 1'b0;
                    done1_d = 1'b0;
                end
            end
            RESP: begin
                if (resp_hs_i) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_o = state_q;
    assign grant_o = grant_q;
    assign done0_o = done0_q;
    assign done1_o = TWO_CH ? done1_q : 1'b1;

endmodule

// File: rtl/axi4_lite_bus_arbiter.sv
// Two-master to one-slave AXI4-lite arbiter; independent round-robin write and
// read paths, one outstanding transaction each. This level only muxes/demuxes.
module axi4_lite_bus_arbiter
    import axi4_lite_pkg::*;
#(
    parameter axi4_lite_cfg_t C         = AXI4_LITE_CFG_DEFAULT,
    parameter bit             FIXED_PRI = 1'b0
) (
    input  logic        aclk,
    input  logic        aresetn,
    axi4_lite_if.slave  axi4_s [2],
    axi4_lite_if.master axi4_m
);

    localparam int unsigned AW = C.A;
    localparam int unsigned DW = C.N * 8;
    localparam int unsigned SW = C.N;

    logic [1:0]    s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic [AW-1:0] s_awaddr [2];
    logic [AW-1:0] s_araddr [2];
    logic [2:0]    s_awprot [2];
    logic [2:0]    s_arprot [2];
    logic [DW-1:0] s_wdata  [2];
    logic [SW-1:0] s_wstrb  [2];

    axi4_lite_arb_state_t wr_state, rd_state;
    logic wr_grant, wr_done0, wr_done1;
    logic rd_grant, rd_done0, rd_done1;
    logic aw_open, w_open, b_open, ar_open, r_open;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    axi4_lite_arb_channel #(.TWO_CH(1'b1), .FIXED_PRI(FIXED_PRI)) u_wr (
        .clk_i      (aclk),
        .rst_ni     (aresetn),
        .req_i      (s_awvalid),
        .addr_hs0_i (aw_hs),
        .addr_hs1_i (w_hs),
        .resp_hs_i  (b_hs),
        .state_o    (wr_state),
        .grant_o    (wr_grant),
        .done0_o    (wr_done0),
        .done1_o    (wr_done1)
    );

    axi4_lite_arb_channel #(.TWO_CH(1'b0), .FIXED_PRI(FIXED_PRI)) u_rd (
        .clk_i      (aclk),
        .rst_ni     (aresetn),
        .req_i      (s_arvalid),
        .addr_hs0_i (ar_hs),
        .addr_hs1_i (1'b0),
        .resp_hs_i  (r_hs),
        .state_o    (rd_state),
        .grant_o    (rd_grant),
        .done0_o    (rd_done0),
        .done1_o    (rd_done1)
    );

    // A channel whose done flag is set stays closed so no beat is repeated.
    assign aw_open = (wr_state == ADDR) && !wr_done0;
    assign w_open  = (wr_state == ADDR) && !wr_done1;
    assign b_open  = (wr_state == RESP);
    assign ar_open = (rd_state == ADDR) && !(rd_done0 && rd_done1);
    assign r_open  = (rd_state == RESP);

    assign axi4_m.awvalid = aw_open && s_awvalid[wr_grant];
    assign axi4_m.awaddr  = s_awaddr[wr_grant];
    assign axi4_m.awprot  = s_awprot[wr_grant];
    assign axi4_m.wvalid  = w_open && s_wvalid[wr_grant];
    assign axi4_m.wdata   = s_wdata[wr_grant];
    assign axi4_m.wstrb   = s_wstrb[wr_grant];
    assign axi4_m.bready  = b_open && s_bready[wr_grant];
    assign axi4_m.arvalid = ar_open && s_arvalid[rd_grant];
    assign axi4_m.araddr  = s_araddr[rd_grant];
    assign axi4_m.arprot  = s_arprot[rd_grant];
    assign axi4_m.rready  = r_open && s_rready[rd_grant];

    assign aw_hs = axi4_m.awvalid && axi4_m.awready;
    assign w_hs  = axi4_m.wvalid && axi4_m.wready;
    assign b_hs  = axi4_m.bvalid && axi4_m.bready;
    assign ar_hs = axi4_m.arvalid && axi4_m.arready;
    assign r_hs  = axi4_m.rvalid && axi4_m.rready;

    for (genvar i = 0; i < 2; i++) begin : g_port
        localparam logic IDX = 1'(i);

        assign s_awvalid[i] = axi4_s[i].awvalid;
        assign s_awaddr[i]  = axi4_s[i].awaddr;
        assign s_awprot[i]  = axi4_s[i].awprot;
        assign s_wvalid[i]  = axi4_s[i].wvalid;
        assign s_wdata[i]   = axi4_s[i].wdata;
        assign s_wstrb[i]   = axi4_s[i].wstrb;
        assign s_bready[i]  = axi4_s[i].bready;
        assign s_arvalid[i] = axi4_s[i].arvalid;
        assign s_araddr[i]  = axi4_s[i].araddr;
        assign s_arprot[i]  = axi4_s[i].arprot;
        assign s_rready[i]  = axi4_s[i].rready;

        assign axi4_s[i].awready = aw_open && (wr_grant == IDX) && axi4_m.awready;
        assign axi4_s[i].wready  = w_open && (wr_grant == IDX) && axi4_m.wready;
        assign axi4_s[i].bvalid  = b_open && (wr_grant == IDX) && axi4_m.bvalid;
        assign axi4_s[i].bresp   = axi4_m.bresp;
        assign axi4_s[i].arready = ar_open && (rd_grant == IDX) && axi4_m.arready;
        assign axi4_s[i].rvalid  = r_open && (rd_grant == IDX) && axi4_m.rvalid;
        assign axi4_s[i].rdata   = axi4_m.rdata;
        assign axi4_s[i].rresp   = axi4_m.rresp;
    end

endmodule

// File: tb/tb_axi4_lite_bus_arbiter.sv
// Directed bench: two bus masters and a memory-backed slave around the arbiter.
module tb_axi4_lite_bus_arbiter;
    import axi4_lite_pkg::*;

    localparam axi4_lite_cfg_t CFG = AXI4_LITE_CFG_DEFAULT;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi4_lite_if #(.C(CFG)) s_if [2] ();
    axi4_lite_if #(.C(CFG)) m_if ();

    axi4_lite_bus_arbiter #(.C(CFG), .FIXED_PRI(1'b0)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .axi4_s  (s_if),
        .axi4_m  (m_if)
    );

    logic        s_awvalid [2];
    logic        s_wvalid  [2];
    logic        s_arvalid [2];
    logic [15:0] s_awaddr  [2];
    logic [15:0] s_araddr  [2];
    logic [31:0] s_wdata   [2];
    logic        s_awready [2];
    logic        s_wready  [2];
    logic        s_arready [2];
    logic        s_bvalid  [2];
    logic        s_rvalid  [2];
    logic [1:0]  s_bresp   [2];
    logic [1:0]  s_rresp   [2];
    logic [31:0] s_rdata   [2];

    for (genvar g = 0; g < 2; g++) begin : g_m
        assign s_if[g].awvalid = s_awvalid[g];
        assign s_if[g].awaddr  = s_awaddr[g];
        assign s_if[g].awprot  = 3'b010;
        assign s_if[g].wvalid  = s_wvalid[g];
        assign s_if[g].wdata   = s_wdata[g];
        assign s_if[g].wstrb   = 4'hF;
        assign s_if[g].bready  = 1'b1;
        assign s_if[g].arvalid = s_arvalid[g];
        assign s_if[g].araddr  = s_araddr[g];
        assign s_if[g].arprot  = 3'b010;
        assign s_if[g].rready  = 1'b1;
        assign s_awready[g] = s_if[g].awready;
        assign s_wready[g]  = s_if[g].wready;
        assign s_arready[g] = s_if[g].arready;
        assign s_bvalid[g]  = s_if[g].bvalid;
        assign s_rvalid[g]  = s_if[g].rvalid;
        assign s_bresp[g]   = s_if[g].bresp;
        assign s_rresp[g]   = s_if[g].rresp;
        assign s_rdata[g]   = s_if[g].rdata;
    end

    // Slave model: resp = addr[3:2], B after b_delay idle cycles, R one cycle after AR.
    int   b_delay  = 0;
    logic aw_block = 1'b0;
    logic w_block  = 1'b0;
    logic [31:0] mem [256];

    assign m_if.awready = aresetn && !aw_block;
    assign m_if.wready  = aresetn && !w_block;
    assign m_if.arready = aresetn;

    initial begin : slave_wr
        logic aw, w, b, have_aw, have_w;
        logic [15:0] a_smp, waddr;
        logic [31:0] d_smp, wdat;
        int bcnt;
        have_aw = 1'b0; have_w = 1'b0; bcnt = 0;
        waddr = '0; wdat = '0;
        m_if.bvalid = 1'b0;
        m_if.bresp  = 2'b00;
        forever begin
            @(negedge aclk);
            aw = m_if.awvalid && m_if.awready;
            w  = m_if.wvalid && m_if.wready;
            b  = m_if.bvalid && m_if.bready;
            a_smp = m_if.awaddr;
            d_smp = m_if.wdata;
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                have_aw = 1'b0; have_w = 1'b0; bcnt = 0;
                m_if.bvalid = 1'b0;
            end else begin
                if (aw) begin have_aw = 1'b1; waddr = a_smp; end
                if (w)  begin have_w = 1'b1; wdat = d_smp; end
                if (b)  m_if.bvalid = 1'b0;
                if (have_aw && have_w && !m_if.bvalid) begin
                    if (bcnt < b_delay) begin
                        bcnt++;
                    end else begin
                        mem[waddr[9:2]] = wdat;
                        m_if.bresp  = waddr[3:2];
                        m_if.bvalid = 1'b1;
                        have_aw = 1'b0; have_w = 1'b0; bcnt = 0;
                    end
                end
            end
        end
    end

    initial begin : slave_rd
        logic ar, r;
        logic [15:0] a_smp;
        m_if.rvalid = 1'b0;
        m_if.rdata  = '0;
        m_if.rresp  = 2'b00;
        forever begin
            @(negedge aclk);
            ar = m_if.arvalid && m_if.arready;
            r  = m_if.rvalid && m_if.rready;
            a_smp = m_if.araddr;
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                m_if.rvalid = 1'b0;
            end else begin
                if (r) m_if.rvalid = 1'b0;
                if (ar) begin
                    m_if.rvalid = 1'b1;
                    m_if.rdata  = mem[a_smp[9:2]];
                    m_if.rresp  = a_smp[3:2];
                end
            end
        end
    end

    int          n_checks = 0;
    int          n_pass = 0;
    int          b_cnt [2];
    int          r_cnt [2];
    logic [1:0]  b_resp_last [2];
    logic [1:0]  r_resp_last [2];
    logic [31:0] r_data_last [2];
    int          b_order [$];
    logic [15:0] aw_log [$];
    logic [31:0] w_log [$];
    logic        p1_any, p1_aw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One bus cycle: sample at the falling edge, act just after the rising edge.
    task automatic tick();
        logic awh [2], wh [2], arh [2], bh [2], rh [2];
        logic [1:0] br [2], rr [2];
        logic [31:0] rd [2];
        logic m_aw, m_w;
        logic [15:0] m_a;
        logic [31:0] m_d;
        @(negedge aclk);
        for (int p = 0; p < 2; p++) begin
            awh[p] = s_awvalid[p] && s_awready[p];
            wh[p]  = s_wvalid[p] && s_wready[p];
            arh[p] = s_arvalid[p] && s_arready[p];
            bh[p]  = s_bvalid[p];
            rh[p]  = s_rvalid[p];
            br[p]  = s_bresp[p];
            rr[p]  = s_rresp[p];
            rd[p]  = s_rdata[p];
        end
        p1_any = p1_any | s_awready[1] | s_wready[1] | s_arready[1] | s_bvalid[1] | s_rvalid[1];
        p1_aw  = p1_aw | s_awready[1] | s_wready[1];
        m_aw = m_if.awvalid && m_if.awready;
        m_w  = m_if.wvalid && m_if.wready;
        m_a  = m_if.awaddr;
        m_d  = m_if.wdata;
        @(posedge aclk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (awh[p]) s_awvalid[p] = 1'b0;
            if (wh[p])  s_wvalid[p] = 1'b0;
            if (arh[p]) s_arvalid[p] = 1'b0;
            if (bh[p]) begin
                b_cnt[p]++;
                b_resp_last[p] = br[p];
                b_order.push_back(p);
            end
            if (rh[p]) begin
                r_cnt[p]++;
                r_resp_last[p] = rr[p];
                r_data_last[p] = rd[p];
            end
        end
        if (m_aw) aw_log.push_back(m_a);
        if (m_w)  w_log.push_back(m_d);
    endtask

    task automatic wait_b(input int p, input int target);
        int n = 0;
        while (b_cnt[p] < target && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_r(input int p, input int target);
        int n = 0;
        while (r_cnt[p] < target && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wr_start(input int p, input logic [15:0] a, input logic [31:0] d);
        s_awvalid[p] = 1'b1;
        s_awaddr[p]  = a;
        s_wvalid[p]  = 1'b1;
        s_wdata[p]   = d;
    endtask

    task automatic rd_start(input int p, input logic [15:0] a);
        s_arvalid[p] = 1'b1;
        s_araddr[p]  = a;
    endtask

    task automatic clear_logs();
        aw_log.delete();
        w_log.delete();
        b_order.delete();
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        for (int p = 0; p < 2; p++) begin
            s_awvalid[p] = 1'b0; s_wvalid[p] = 1'b0; s_arvalid[p] = 1'b0;
            s_awaddr[p] = '0; s_araddr[p] = '0; s_wdata[p] = '0;
            b_cnt[p] = 0; r_cnt[p] = 0;
            b_resp_last[p] = '0; r_resp_last[p] = '0; r_data_last[p] = '0;
        end
        p1_any = 1'b0;
        p1_aw  = 1'b0;
        repeat (3) @(posedge aclk);
        #1;

        chk("rst_m_awvalid", 32'(m_if.awvalid), 0);
        chk("rst_m_wvalid", 32'(m_if.wvalid), 0);
        chk("rst_m_arvalid", 32'(m_if.arvalid), 0);
        chk("rst_m_bready", 32'(m_if.bready), 0);
        chk("rst_m_rready", 32'(m_if.rready), 0);
        chk("rst_s0_awready", 32'(s_awready[0]), 0);
        chk("rst_s1_arready", 32'(s_arready[1]), 0);
        chk("rst_s0_bvalid", 32'(s_bvalid[0]), 0);
        aresetn = 1'b1;
        tick();

        // Single write then read-back from port 0.
        clear_logs();
        p1_any = 1'b0;
        wr_start(0, 16'h0004, 32'hABBA_BEEF);
        chk("t1_idle_not_fwd", 32'(m_if.awvalid), 0);
        tick();
        chk("t1_aw_fwd_after_grant", 32'(m_if.awvalid), 1);
        chk("t1_w_fwd_after_grant", 32'(m_if.wvalid), 1);
        wait_b(0, 1);
        chk("t1_b_cnt0", 32'(b_cnt[0]), 1);
        chk("t1_aw_beats", 32'(aw_log.size()), 1);
        chk("t1_awaddr", 32'(aw_log[0]), 32'h0004);
        chk("t1_wdata", w_log[0], 32'hABBA_BEEF);
        chk("t1_bresp", 32'(b_resp_last[0]), 1);
        rd_start(0, 16'h0004);
        wait_r(0, 1);
        chk("t1_r_cnt0", 32'(r_cnt[0]), 1);
        chk("t1_rdata", r_data_last[0], 32'hABBA_BEEF);
        chk("t1_rresp", 32'(r_resp_last[0]), 1);
        chk("t1_p1_quiet", 32'(p1_any), 0);

        // Fresh pointer: simultaneous pair goes port 0 then port 1.
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        clear_logs();
        wr_start(0, 16'h0010, 32'h1111_1111);
        wr_start(1, 16'h0110, 32'h2222_2222);
        wait_b(1, 1);
        chk("t2_b_cnt1", 32'(b_cnt[1]), 1);
        chk("t2_b_cnt0", 32'(b_cnt[0]), 2);
        chk("t2_order_len", 32'(b_order.size()), 2);
        chk("t2_first_b", 32'(b_order[0]), 0);
        chk("t2_second_b", 32'(b_order[1]), 1);
        chk("t2_first_aw", 32'(aw_log[0]), 32'h0010);
        chk("t2_second_aw", 32'(aw_log[1]), 32'h0110);
        chk("t2_second_w", w_log[1], 32'h2222_2222);

        // A lone port 0 write leaves port 0 as last grant, so the next tie goes to port 1.
        clear_logs();
        wr_start(0, 16'h0018, 32'h3333_3333);
        wait_b(0, 3);
        chk("t2_solo_b", 32'(b_cnt[0]), 3);
        clear_logs();
        wr_start(0, 16'h0020, 32'h4444_4444);
        wr_start(1, 16'h0120, 32'h5555_5555);
        wait_b(0, 4);
        chk("t2b_b_cnt0", 32'(b_cnt[0]), 4);
        chk("t2b_first_b", 32'(b_order[0]), 1);
        chk("t2b_second_b", 32'(b_order[1]), 0);
        chk("t2b_first_aw", 32'(aw_log[0]), 32'h0120);
        chk("t2b_second_aw", 32'(aw_log[1]), 32'h0020);

        // W presented before AW, then AW stalled downstream after W completes.
        clear_logs();
        aw_block = 1'b1;
        s_wvalid[0] = 1'b1;
        s_wdata[0]  = 32'h6666_6666;
        tick();
        tick();
        chk("t3_w_held_in_idle", 32'(w_log.size()), 0);
        s_awvalid[0] = 1'b1;
        s_awaddr[0]  = 16'h0030;
        tick();
        tick();
        chk("t3_w_beat_done", 32'(w_log.size()), 1);
        s_wvalid[0] = 1'b1;
        chk("t3_w_suppressed", 32'(m_if.wvalid), 0);
        chk("t3_wready_blocked", 32'(s_wready[0]), 0);
        chk("t3_aw_pending", 32'(m_if.awvalid), 1);
        tick();
        aw_block = 1'b0;
        wait_b(0, 5);
        s_wvalid[0] = 1'b0;
        chk("t3_b_cnt0", 32'(b_cnt[0]), 5);
        chk("t3_b_cnt1", 32'(b_cnt[1]), 2);
        chk("t3_w_beats", 32'(w_log.size()), 1);
        chk("t3_aw_beats", 32'(aw_log.size()), 1);
        chk("t3_awaddr", 32'(aw_log[0]), 32'h0030);

        // Port 0 write and port 1 read granted in the same cycle.
        clear_logs();
        wr_start(0, 16'h0038, 32'h8888_8888);
        rd_start(1, 16'h0110);
        tick();
        chk("t4_aw_granted", 32'(m_if.awvalid), 1);
        chk("t4_ar_granted", 32'(m_if.arvalid), 1);
        wait_b(0, 6);
        wait_r(1, 1);
        chk("t4_b_cnt0", 32'(b_cnt[0]), 6);
        chk("t4_r_cnt1", 32'(r_cnt[1]), 1);
        chk("t4_rdata1", r_data_last[1], 32'h2222_2222);
        chk("t4_rresp1", 32'(r_resp_last[1]), 0);
        chk("t4_r_cnt0", 32'(r_cnt[0]), 1);
        chk("t4_b_cnt1", 32'(b_cnt[1]), 2);

        // Slow B: port 1 must wait for port 0's response handshake.
        clear_logs();
        b_delay = 20;
        wr_start(0, 16'h0040, 32'h9999_9999);
        tick();
        wr_start(1, 16'h0140, 32'hAAAA_5555);
        p1_aw = 1'b0;
        wait_b(0, 7);
        chk("t5_b_cnt0", 32'(b_cnt[0]), 7);
        chk("t5_p1_not_granted", 32'(p1_aw), 0);
        chk("t5_aw_beats", 32'(aw_log.size()), 1);
        b_delay = 0;
        wait_b(1, 3);
        chk("t5_b_cnt1", 32'(b_cnt[1]), 3);
        chk("t5_p1_aw", 32'(aw_log[1]), 32'h0140);

        // Reset while in the address phase with AW already accepted.
        clear_logs();
        w_block = 1'b1;
        wr_start(0, 16'h0050, 32'hBBBB_BBBB);
        tick();
        tick();
        chk("t6_aw_done", 32'(aw_log.size()), 1);
        chk("t6_w_pending", 32'(m_if.wvalid), 1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_rst_wvalid", 32'(m_if.wvalid), 0);
        chk("t6_rst_awvalid", 32'(m_if.awvalid), 0);
        chk("t6_rst_wready0", 32'(s_wready[0]), 0);
        chk("t6_rst_bready", 32'(m_if.bready), 0);
        for (int p = 0; p < 2; p++) begin
            s_awvalid[p] = 1'b0;
            s_wvalid[p]  = 1'b0;
        end
        tick();
        tick();
        aresetn = 1'b1;
        w_block = 1'b0;
        clear_logs();
        wr_start(1, 16'h0150, 32'hCCCC_CCCC);
        wait_b(1, 4);
        chk("t6_b_cnt1", 32'(b_cnt[1]), 4);
        chk("t6_no_b_port0", 32'(b_cnt[0]), 7);
        chk("t6_awaddr", 32'(aw_log[0]), 32'h0150);
        chk("t6_wdata", w_log[0], 32'hCCCC_CCCC);
        chk("t6_bresp", 32'(b_resp_last[1]), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
